// File: rtl/control_sequencer_pkg.sv
// Shared state codes, instruction classes and strobe bundle for the control sequencer.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package control_sequencer_pkg;

    // Sequencer state codes (3-bit, debug-visible on the state port)
    localparam logic [2:0] ST_RESET   = 3'd0;
    localparam logic [2:0] ST_FETCH   = 3'd1;
    localparam logic [2:0] ST_DECODE  = 3'd2;
    localparam logic [2:0] ST_EXECUTE = 3'd3;
    localparam logic [2:0] ST_MEM     = 3'd4;
    localparam logic [2:0] ST_WB      = 3'd5;
    localparam logic [2:0] ST_EXC     = 3'd6;
    localparam logic [2:0] ST_FAULT   = 3'd7;

    // Instruction classes produced by the instruction register
    localparam logic [4:0] INST_DP      = 5'h01;
    localparam logic [4:0] INST_MOV_LAS = 5'h02;
    localparam logic [4:0] INST_LDST    = 5'h03;
    localparam logic [4:0] INST_B       = 5'h04;
    localparam logic [4:0] INST_MSR_PM  = 5'h05;
    localparam logic [4:0] INST_CPS     = 5'h06;
    localparam logic [4:0] INST_UNDEF   = 5'h1F;

    // All datapath strobes driven by the sequencer in one bundle
    typedef struct packed {
        logic wr_en;
        logic cu_decode;
        logic ld_sp;
        logic ld_lr;
        logic ld_pc;
        logic ld_rd;
        logic ld_apsr;
        logic ld_ipsr;
        logic ld_primask;
        logic irq_ack;
    } strobe_t;

    // True for every class the sequencer knows how to execute
    function automatic logic is_known_inst(input logic [4:0] cls);
        return (cls == INST_DP) || (cls == INST_MOV_LAS) || (cls == INST_LDST) ||
               (cls == INST_B) || (cls == INST_MSR_PM) || (cls == INST_CPS);
    endfunction

endpackage

// File: rtl/control_sequencer_mem_wait_timer.sv
// Counts memory wait cycles; flags the last allowed wait cycle before a timeout.
// Latency: expired is combinational from the count register.
// Backpressure: none; clr has priority over en.
module control_sequencer_mem_wait_timer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic idle,
    output logic expired
);
    localparam int TW = $clog2(MEM_TIMEOUT);
    localparam logic [TW-1:0] LAST = TW'(MEM_TIMEOUT - 1);

    logic [TW-1:0] cnt;

    // Wait-cycle counter: cleared on state change / stall, advanced on each unanswered access cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + TW'(1);
        end
    end

    // The cycle in which cnt==LAST is the MEM_TIMEOUT-th wait cycle
    assign expired = (cnt == LAST);
    assign idle    = (cnt == '0);

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEM/WB sequencer with interrupt entry, fault trap and retire count.
// Latency: strobes are combinational from current state and inputs; state advances once per clock.
// Backpressure: waits on mem_ready in FETCH/MEM (bounded by MEM_TIMEOUT), stalls in FETCH while run=0.
module control_sequencer
    import control_sequencer_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [4:0]       inst,
    input  logic             S,
    input  logic             L,
    input  logic             br_L,
    input  logic             cond_pass,
    input  logic             mem_ready,
    input  logic             irq_req,
    input  logic             PMask,
    output logic             wr_en,
    output logic             cu_decode,
    output logic             ld_sp,
    output logic             ld_lr,
    output logic             ld_pc,
    output logic             ld_rd,
    output logic             ld_apsr,
    output logic             ld_ipsr,
    output logic             ld_primask,
    output logic             irq_ack,
    output logic             fault,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired
);
    logic [2:0] cur_state;
    logic [2:0] nxt_state;
    strobe_t    stb;
    logic       retire;
    logic       wait_cyc;
    logic       stall_clr;
    logic       tmr_idle;
    logic       tmr_expired;

    control_sequencer_mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     ((nxt_state != cur_state) || stall_clr),
        .en      (wait_cyc),
        .idle    (tmr_idle),
        .expired (tmr_expired)
    );

    // Next-state and strobe decode; every strobe is forced low while reset is asserted
    always_comb begin
        nxt_state = cur_state;
        stb       = '0;
        retire    = 1'b0;
        wait_cyc  = 1'b0;
        stall_clr = 1'b0;
        case (cur_state)
            ST_RESET: begin
                stb.ld_sp = 1'b1;
                stb.ld_pc = 1'b1;
                nxt_state = ST_FETCH;
            end
            ST_FETCH: begin
                // Interrupts are only taken before a fetch access has started waiting
                if (irq_req && !PMask && tmr_idle) begin
                    nxt_state = ST_EXC;
                end else if (!run) begin
                    stall_clr = 1'b1;
                end else if (mem_ready) begin
                    nxt_state = ST_DECODE;
                end else begin
                    wait_cyc = 1'b1;
                    if (tmr_expired) nxt_state = ST_FAULT;
                end
            end
            ST_DECODE: begin
                stb.cu_decode = 1'b1;
                nxt_state     = is_known_inst(inst) ? ST_EXECUTE : ST_FAULT;
            end
            ST_EXECUTE: begin
                if (!cond_pass) begin
                    stb.ld_pc = 1'b1;
                    retire    = 1'b1;
                    nxt_state = ST_FETCH;
                end else begin
                    case (inst)
                        INST_DP, INST_MOV_LAS: begin
                            stb.ld_rd   = 1'b1;
                            stb.ld_apsr = S;
                            stb.ld_pc   = 1'b1;
                            retire      = 1'b1;
                            nxt_state   = ST_FETCH;
                        end
                        INST_LDST: nxt_state = ST_MEM;
                        INST_B: begin
                            stb.ld_pc = 1'b1;
                            stb.ld_lr = br_L;
                            retire    = 1'b1;
                            nxt_state = ST_FETCH;
                        end
                        INST_MSR_PM, INST_CPS: begin
                            stb.ld_primask = 1'b1;
                            stb.ld_pc      = 1'b1;
                            retire         = 1'b1;
                            nxt_state      = ST_FETCH;
                        end
                        default: nxt_state = ST_FAULT;
                    endcase
                end
            end
            ST_MEM: begin
                stb.wr_en = !L;
                if (mem_ready) begin
                    if (L) begin
                        nxt_state = ST_WB;
                    end else begin
                        stb.ld_pc = 1'b1;
                        retire    = 1'b1;
                        nxt_state = ST_FETCH;
                    end
                end else begin
                    wait_cyc = 1'b1;
                    if (tmr_expired) nxt_state = ST_FAULT;
                end
            end
            ST_WB: begin
                stb.ld_rd = 1'b1;
                stb.ld_pc = 1'b1;
                retire    = 1'b1;
                nxt_state = ST_FETCH;
            end
            ST_EXC: begin
                stb.ld_sp   = 1'b1;
                stb.ld_lr   = 1'b1;
                stb.ld_ipsr = 1'b1;
                stb.ld_pc   = 1'b1;
                stb.irq_ack = 1'b1;
                nxt_state   = ST_FETCH;
            end
            default: nxt_state = ST_FAULT;
        endcase
        if (!rst) stb = '0;
    end

    // State register; async clear aborts any instruction in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cur_state <= ST_RESET;
        else      cur_state <= nxt_state;
    end

    // Retired-instruction counter, wraps naturally at 2^CNT_W
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        retired <= '0;
        else if (retire) retired <= retired + CNT_W'(1);
    end

    assign wr_en      = stb.wr_en;
    assign cu_decode  = stb.cu_decode;
    assign ld_sp      = stb.ld_sp;
    assign ld_lr      = stb.ld_lr;
    assign ld_pc      = stb.ld_pc;
    assign ld_rd      = stb.ld_rd;
    assign ld_apsr    = stb.ld_apsr;
    assign ld_ipsr    = stb.ld_ipsr;
    assign ld_primask = stb.ld_primask;
    assign irq_ack    = stb.irq_ack;
    assign fault      = (cur_state == ST_FAULT);
    assign state      = cur_state;

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
Multi-cycle control unit driving the Datapath control inputs: wr_en, cu_decode, ld_sp, ld_lr, ld_pc, ld_rd, ld_apsr, ld_ipsr and ld_primask.
- Runs the FETCH → DECODE → EXECUTE → (MEM → WB) sequence for each instruction.
- Takes interrupts between instructions, traps undefined classes and memory timeouts into a sticky FAULT, and counts retired instructions.

Parameters:
MEM_TIMEOUT, 16, max cycles waiting for mem_ready in FETCH or MEM before FAULT (≥2).
CNT_W, 32, width of retired-instruction counter.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-low reset
run  in  1  1 = may start new fetch; 0 = stall in FETCH after current instruction
inst  in  5  instruction class from InstructionReg
S  in  1  set-condition-codes bit
L  in  1  load(1)/store(0) bit of single_trans_f
br_L  in  1  branch link bit
cond_pass  in  1  condition check result for current instruction
mem_ready  in  1  memory handshake: access complete this cycle
irq_req  in  1  pending interrupt (level)
PMask  in  1  PRIMASK; 1 masks irq_req
wr_en  out  1  memory write enable
cu_decode  out  1  decode strobe
ld_sp, ld_lr, ld_pc, ld_rd, ld_apsr, ld_ipsr, ld_primask  out  1 each  register load strobes
irq_ack  out  1  one-cycle pulse on exception entry
fault  out  1  sticky fault flag
state  out  3  current state encoding (debug)
retired  out  CNT_W  retired-instruction count

Behaviour:
- State register and counters are flops with async clear on rst=0. Strobe outputs are combinational from current state and current inputs.
- While rst=0: state=RESET, all strobes=0, irq_ack=0, fault=0, retired=0, timeout count=0.
- Reset mid-operation aborts immediately; no partial strobes are issued afterwards.
- RESET (first cycle after release): ld_sp=1, ld_pc=1 (vector load); next state FETCH.
- FETCH:
  - If irq_req & !PMask at entry → EXC. Interrupts are checked before run.
  - Else if run=0 → stay in FETCH, timer held at 0.
  - Else wait for mem_ready; mem_ready=1 → DECODE.
  - Timer counts cycles with mem_ready=0; reaching MEM_TIMEOUT → FAULT.
- DECODE: cu_decode=1 for exactly one cycle. inst=INST_UNDEF or any unlisted code → FAULT; else → EXECUTE.
- EXECUTE with cond_pass=0: ld_pc=1 only; instruction is retired; → FETCH.
- EXECUTE with cond_pass=1, by class:
  - INST_DP, INST_MOV_LAS: ld_rd=1, ld_apsr=S, ld_pc=1 → FETCH.
  - INST_LDST: no strobes → MEM.
  - INST_B: ld_pc=1, ld_lr=br_L → FETCH.
  - INST_MSR_PM, INST_CPS: ld_primask=1, ld_pc=1 → FETCH.
- MEM:
  - Store (L=0): wr_en=1 every cycle until mem_ready=1. In that cycle ld_pc=1 → FETCH.
  - Load (L=1): wr_en=0; on mem_ready=1 → WB.
  - Timeout rule is the same as FETCH; on timeout wr_en drops in the FAULT cycle.
- WB: ld_rd=1, ld_pc=1 → FETCH.
- EXC (one cycle): ld_sp=1, ld_lr=1, ld_ipsr=1, ld_pc=1, irq_ack=1 → FETCH. The next FETCH re-samples irq_req, so back-to-back interrupts are allowed.
- FAULT: absorbing until rst=0; fault=1; all strobes 0.
- retired increments by 1 in every cycle whose transition is EXECUTE→FETCH, WB→FETCH or MEM→FETCH (store). EXC and RESET do not count. Counter wraps 2^CNT_W−1 → 0.
- No strobe is asserted in two consecutive instruction phases except as listed above.
- Timer clears on every state change.

Decomposition:
- Shared package (Defines.v additions):
  - State codes: RESET=0, FETCH=1, DECODE=2, EXECUTE=3, MEM=4, WB=5, EXC=6, FAULT=7.
  - Instruction class codes: INST_DP=5'h01, INST_MOV_LAS=`MOV_LAS (existing code, unchanged), INST_LDST=5'h03, INST_B=5'h04, INST_MSR_PM=5'h05, INST_CPS=5'h06, INST_UNDEF=5'h1F.
- Optional sub-module mem_wait_timer: timeout counter with clear/enable and an expired output, shared by FETCH and MEM.

Test Plan:
- rst=0 for 3 cycles, then release → RESET one cycle with ld_sp=ld_pc=1, then FETCH; retired=0, fault=0.
- Fetch mem_ready after 2 wait cycles, inst=INST_DP, S=1, cond_pass=1 → cu_decode pulse, then EXECUTE with ld_rd=ld_apsr=ld_pc=1; retired=1.
- INST_LDST, L=0, mem_ready delayed 3 cycles in MEM → wr_en=1 for 4 cycles, ld_pc on the 4th; L=1 variant → WB with ld_rd=ld_pc=1, wr_en stays 0.
- INST_B, br_L=1, cond_pass=0 → only ld_pc=1 and no ld_lr; repeat with cond_pass=1 → ld_pc=ld_lr=1.
- irq_req=1, PMask=0 at FETCH entry → EXC with ld_sp/ld_lr/ld_ipsr/ld_pc/irq_ack=1, retired unchanged; PMask=1 → no EXC.
- mem_ready held 0 for 16 cycles in FETCH → FAULT, fault=1 sticky; inst=5'h1F at DECODE → FAULT; rst=0 mid-MEM store → wr_en=0 asynchronously.
